// File: rtl/sha_mem_pkg.sv
// sha_mem_pkg: shared arbiter state type and memory-port widths for the SHA cores
package sha_mem_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;

    typedef enum logic {
        IDLE,
        OWN
    } arb_state_t;

endpackage

// File: rtl/sha_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin scan returning a one-hot pick starting after last
module rr_pick #(
    parameter int N  = 4,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  pick,
    output logic          any
);

    logic [LW-1:0] idx;

    assign any = |req;

    // scan offsets from far to near so the nearest set index after last wins
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = LW'((int'(last) + k) % N);
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha_mem_arbiter.sv
// sha_mem_arbiter: round-robin locked-burst arbiter sharing one memory port among N_REQ cores
// Optional burst limit: define SHA_MEM_ARB_BURST_LIMIT_EN to preempt an owner after MAX_BURST accesses.
module sha_mem_arbiter
    import sha_mem_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*MEM_ADDR_W-1:0] req_addr,
    input  logic [N_REQ*MEM_DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rd_valid,
    output logic [MEM_DATA_W-1:0]       rd_data,
    output logic                        mem_clk,
    output logic                        mem_we,
    output logic [MEM_ADDR_W-1:0]       mem_addr,
    output logic [MEM_DATA_W-1:0]       mem_write_data,
    input  logic [MEM_DATA_W-1:0]       mem_read_data
);

    localparam int LW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n
        $error("sha_mem_arbiter: N_REQ out of range");
    end
    if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_burst
        $error("sha_mem_arbiter: MAX_BURST out of range");
    end

    arb_state_t            state;
    logic [LW-1:0]         owner;
    logic [LW-1:0]         last;
    logic [LW-1:0]         pick_idx;
    logic [N_REQ-1:0]      pick;
    logic                  any;
    logic                  accept;
    logic                  own_we;
    logic [MEM_ADDR_W-1:0] own_addr;
    logic [MEM_DATA_W-1:0] own_wdata;
    logic                  burst_end;

    assign mem_clk = clk;
    assign rd_data = mem_read_data;

    rr_pick #(.N(N_REQ)) u_pick (
        .req  (req),
        .last (last),
        .pick (pick),
        .any  (any)
    );

    // encode the one-hot pick back to an owner index
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = LW'(i);
        end
    end

    // mux the registered owner's access onto the memory; zeros whenever nothing is accepted
    always_comb begin
        own_we         = req_we[owner];
        own_addr       = req_addr[MEM_ADDR_W*int'(owner) +: MEM_ADDR_W];
        own_wdata      = req_wdata[MEM_DATA_W*int'(owner) +: MEM_DATA_W];
        accept         = (state == OWN) && req[owner];
        mem_we         = accept && own_we;
        mem_addr       = accept ? own_addr : '0;
        mem_write_data = accept ? own_wdata : '0;
    end

`ifdef SHA_MEM_ARB_BURST_LIMIT_EN
    logic [7:0] burst_cnt;

    assign burst_end = ({1'b0, burst_cnt} + 9'd1) == 9'(MAX_BURST);

    // count accepted accesses of the current grant; idle clears it before every new grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) burst_cnt <= '0;
        else if (state == IDLE) burst_cnt <= '0;
        else if (accept) burst_cnt <= burst_cnt + 8'd1;
    end
`else
    assign burst_end = 1'b0;
`endif

    // grant FSM: pick a new owner from IDLE, hold it until release or burst exhaustion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= '0;
            last  <= LW'(N_REQ - 1);
            gnt   <= '0;
        end else if (state == IDLE) begin
            if (any) begin
                state <= OWN;
                owner <= pick_idx;
                last  <= pick_idx;
                gnt   <= pick;
            end
        end else if (!req[owner] || burst_end) begin
            state <= IDLE;
            gnt   <= '0;
        end
    end

    // tag each accepted read with its issuer so the return lands there next cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_valid <= '0;
        else rd_valid <= (accept && !own_we) ? (N_REQ'(1) << owner) : '0;
    end

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// tb_sha_mem_arbiter: directed checks of grant order, burst timing, read routing, write isolation and reset
module tb_sha_mem_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*16-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rd_valid;
    logic [31:0]     rd_data;
    logic            mem_clk;
    logic            mem_we;
    logic [15:0]     mem_addr;
    logic [31:0]     mem_write_data;
    logic [31:0]     mem_read_data;

    logic [31:0] mem [256];
    int          vectors = 0;
    int          errors  = 0;
    int          acc [N];
    logic [3:0]  exp_g;

    sha_mem_arbiter #(.N_REQ(N), .MAX_BURST(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .gnt            (gnt),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_write_data;
        mem_read_data <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic r, input logic we, input logic [15:0] a, input logic [31:0] d);
        req[c]               = r;
        req_we[c]            = we;
        req_addr[16*c +: 16] = a;
        req_wdata[32*c +: 32] = d;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 + i;
        do_reset();
        #1;
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_mem_we", 32'(mem_we), 0);
        chk("reset_mem_addr", 32'(mem_addr), 0);

        // single core 16-read burst
        drive(0, 1, 0, 16'h0000, 0);
        #1;
        chk("burst_idle_gnt", 32'(gnt), 0);
        for (int i = 0; i < 16; i++) begin
            next_cycle();
            drive(0, 1, 0, 16'(i), 0);
            #1;
            chk("burst_gnt", 32'(gnt), 32'h1);
            chk("burst_addr", 32'(mem_addr), i);
            chk("burst_we", 32'(mem_we), 0);
            chk("burst_rd_valid", 32'(rd_valid), (i == 0) ? 0 : 1);
            if (i > 0) chk("burst_rd_data", rd_data, 32'hC0DE0000 + i - 1);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("burst_last_rd_valid", 32'(rd_valid), 32'h1);
        chk("burst_last_rd_data", rd_data, 32'hC0DE000F);
        chk("burst_release_addr", 32'(mem_addr), 0);
        chk("burst_release_gnt", 32'(gnt), 32'h1);
        next_cycle();
        #1;
        chk("burst_after_gnt", 32'(gnt), 0);
        chk("burst_after_rd_valid", 32'(rd_valid), 0);

        // four-way contention, 4 accesses each, from reset priority
        do_reset();
        for (int c = 0; c < N; c++) begin
            acc[c] = 0;
            drive(c, 1, 0, 16'(16 * c), 0);
        end
        #1;
        chk("rr_gnt_c0", 32'(gnt), 0);
        for (int cy = 1; cy <= 24; cy++) begin
            next_cycle();
            for (int c = 0; c < N; c++) req[c] = acc[c] < 4;
            #1;
            exp_g = ((cy - 1) % 6 == 5) ? 4'b0000 : 4'(1 << ((cy - 1) / 6));
            chk("rr_gnt", 32'(gnt), 32'(exp_g));
            for (int c = 0; c < N; c++) if (gnt[c] && req[c]) acc[c]++;
        end

        // fairness: after core 2 releases, core 3 goes before core 0
        next_cycle();
        req = 4'b0100;
        #1;
        chk("fair_idle_gnt", 32'(gnt), 0);
        next_cycle();
        req = 4'b1101;
        #1;
        chk("fair_gnt2", 32'(gnt), 32'h4);
        next_cycle();
        req = 4'b1001;
        #1;
        chk("fair_release_gnt2", 32'(gnt), 32'h4);
        next_cycle();
        #1;
        chk("fair_handoff_gnt", 32'(gnt), 0);
        next_cycle();
        req = 4'b0001;
        #1;
        chk("fair_gnt3", 32'(gnt), 32'h8);
        chk("fair_zero_access_addr", 32'(mem_addr), 0);
        next_cycle();
        #1;
        chk("fair_idle2_gnt", 32'(gnt), 0);
        next_cycle();
        #1;
        chk("fair_gnt0", 32'(gnt), 32'h1);

        // write isolation: core 1 tries to write 0x0040 while core 0 reads 0x0020
        drive(1, 1, 1, 16'h0040, 32'hDEADBEEF);
        drive(0, 1, 0, 16'h0020, 0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            chk("iso_gnt", 32'(gnt), 32'h1);
            chk("iso_mem_we", 32'(mem_we), 0);
            chk("iso_mem_addr", 32'(mem_addr), 32'h20);
        end
        next_cycle();
        drive(0, 1, 1, 16'h0030, 32'h12345678);
        #1;
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h30);
        chk("wr_mem_data", mem_write_data, 32'h12345678);
        next_cycle();
        drive(0, 1, 0, 16'h0030, 0);
        #1;
        chk("wr_no_rd_valid", 32'(rd_valid), 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        #1;
        chk("wr_readback_valid", 32'(rd_valid), 32'h1);
        chk("wr_readback_data", rd_data, 32'h12345678);
        chk("iso_mem_untouched", mem[8'h40], 32'hC0DE0040);
        next_cycle();
        #1;
        chk("wr_release_gnt", 32'(gnt), 0);

        // long burst from core 0 with core 1 waiting
        next_cycle();
        drive(0, 1, 0, 0, 0);
        #1;
        next_cycle();
        drive(1, 1, 0, 16'h0010, 0);
        #1;
        chk("long_gnt_first", 32'(gnt), 32'h1);
`ifdef SHA_MEM_ARB_BURST_LIMIT_EN
        for (int i = 2; i <= 16; i++) begin
            next_cycle();
            #1;
            chk("long_gnt_hold", 32'(gnt), 32'h1);
        end
        next_cycle();
        #1;
        chk("long_preempt_gnt", 32'(gnt), 0);
        next_cycle();
        #1;
        chk("long_next_gnt1", 32'(gnt), 32'h2);
`else
        for (int i = 2; i <= 40; i++) begin
            next_cycle();
            #1;
            chk("long_gnt_hold", 32'(gnt), 32'h1);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("long_release_gnt", 32'(gnt), 32'h1);
        next_cycle();
        #1;
        chk("long_handoff_gnt", 32'(gnt), 0);
        next_cycle();
        #1;
        chk("long_next_gnt1", 32'(gnt), 32'h2);
`endif
        next_cycle();
        req = '0;
        #1;
        next_cycle();
        #1;
        chk("long_done_gnt", 32'(gnt), 0);

        // reset during the 5th read of a burst
        next_cycle();
        drive(0, 1, 0, 16'h0050, 0);
        #1;
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            drive(0, 1, 0, 16'(16'h0050 + i - 1), 0);
            #1;
            chk("mid_gnt", 32'(gnt), 32'h1);
        end
        next_cycle();
        drive(0, 1, 0, 16'h0054, 0);
        #1;
        chk("mid_pre_rd_valid", 32'(rd_valid), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_gnt", 32'(gnt), 0);
        chk("mid_reset_rd_valid", 32'(rd_valid), 0);
        chk("mid_reset_mem_we", 32'(mem_we), 0);
        chk("mid_reset_mem_addr", 32'(mem_addr), 0);
        next_cycle();
        req = 4'b0101;
        reset_n = 1'b1;
        #1;
        chk("post_reset_idle_gnt", 32'(gnt), 0);
        next_cycle();
        #1;
        chk("post_reset_pick0", 32'(gnt), 32'h1);
        chk("post_reset_no_return", 32'(rd_valid), 0);
        req = '0;
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
